// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered, handshaked RV32I immediate generator for the decode stage.
//   Decodes the U/I/B/S/J immediate formats (and, optionally, the CSR zimm
//   Z format) from the raw instruction word, extends the result to XLEN bits,
//   and passes it through a 2-entry elastic buffer: an output register plus a
//   skid register. The buffer sustains one entry per cycle, and in_ready
//   depends only on registered state and rst.
//
//   Optional feature macro: IMM_ZEXT_EN
//     defined   -> ImmSrc=101 yields zero-extended Instr[19:15], legal
//     undefined -> ImmSrc=101 is illegal; no Z decode logic is built
//
//   Parameters
//     XLEN        output width, 32 or 64; upper bits replicate the sign
//
//   Ports
//     clk         clock, all state changes on posedge
//     rst         synchronous active-high reset
//     flush       drops every buffered entry and the entry accepted this cycle
//     in_valid    upstream entry valid
//     in_ready    buffer can accept (skid slot empty and not in reset)
//     Instr       raw 32-bit instruction word
//     ImmSrc      immediate format select
//     out_valid   ImmExt/ImmIllegal hold a valid entry
//     out_ready   downstream accepts the presented entry
//     ImmExt      extended immediate
//     ImmIllegal  ImmSrc code not supported; ImmExt is zero in that case
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            ImmIllegal
);

    logic [31:0]     decImm32;
    logic            decIll;
    logic [XLEN-1:0] decImm;

    logic            accept;
    logic            emit;

    logic            outValid_q,  outValid_d;
    logic [XLEN-1:0] outImm_q,    outImm_d;
    logic            outIll_q,    outIll_d;
    logic            skidValid_q, skidValid_d;
    logic [XLEN-1:0] skidImm_q,   skidImm_d;
    logic            skidIll_q,   skidIll_d;

    // The opcode field never contributes to an immediate.
    logic unusedOpcode;
    assign unusedOpcode = ^Instr[6:0];

    // Format decode into a 32-bit immediate. Unsupported codes produce zero
    // and raise the illegal flag, but still travel through the buffer.
    always_comb begin
        decImm32 = '0;
        decIll   = 1'b0;
        case (ImmSrc)
            3'b000: decImm32 = {Instr[31:12], 12'b0};
            3'b001: decImm32 = {{20{Instr[31]}}, Instr[31:20]};
            3'b010: decImm32 = {{19{Instr[31]}}, Instr[31], Instr[7],
                                Instr[30:25], Instr[11:8], 1'b0};
            3'b011: decImm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            3'b100: decImm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12],
                                Instr[20], Instr[30:21], 1'b0};
`ifdef IMM_ZEXT_EN
            3'b101: decImm32 = {27'b0, Instr[19:15]};
`endif
            default: begin
                decImm32 = '0;
                decIll   = 1'b1;
            end
        endcase
    end

    // Widening to XLEN. Bit 31 of the 32-bit result equals Instr[31] for every
    // sign-extended format and is 0 for zimm and illegal codes, so it is the
    // right fill bit in all cases.
    generate
        if (XLEN > 32) begin : gWiden
            assign decImm = {{(XLEN-32){decImm32[31]}}, decImm32};
        end else begin : gNarrow
            assign decImm = decImm32;
        end
    endgenerate

    // Handshake events. The skid slot being full is the only thing that
    // stops the buffer from accepting.
    assign in_ready = !skidValid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign emit     = outValid_q && out_ready;

    // Buffer next state. When the output slot frees up, the skid entry has
    // priority over a new arrival; in_ready is low whenever the skid slot is
    // full, so the two can never compete. A new arrival goes to the skid slot
    // only while the output slot is stalled. Flush clears the valid bits and
    // leaves stale data behind.
    always_comb begin
        outValid_d  = outValid_q;
        outImm_d    = outImm_q;
        outIll_d    = outIll_q;
        skidValid_d = skidValid_q;
        skidImm_d   = skidImm_q;
        skidIll_d   = skidIll_q;
        if (flush) begin
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
        end else if (!outValid_q || emit) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outImm_d    = skidImm_q;
                outIll_d    = skidIll_q;
                skidValid_d = 1'b0;
            end else if (accept) begin
                outValid_d = 1'b1;
                outImm_d   = decImm;
                outIll_d   = decIll;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (accept) begin
            skidValid_d = 1'b1;
            skidImm_d   = decImm;
            skidIll_d   = decIll;
        end
    end

    // State registers. Reset clears data as well as the valid bits, so that
    // ImmExt and ImmIllegal read as zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outImm_q    <= '0;
            outIll_q    <= 1'b0;
            skidValid_q <= 1'b0;
            skidImm_q   <= '0;
            skidIll_q   <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            outImm_q    <= outImm_d;
            outIll_q    <= outIll_d;
            skidValid_q <= skidValid_d;
            skidImm_q   <= skidImm_d;
            skidIll_q   <= skidIll_d;
        end
    end

    assign out_valid  = outValid_q;
    assign ImmExt     = outImm_q;
    assign ImmIllegal = outIll_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Self-checking bench for imm_gen_pipe. One instance uses XLEN=32 and a
//   second uses XLEN=64. Both share every input. The bench has three parts:
//   a table of directed decode vectors, hand-written backpressure, flush and
//   reset sequences, and a randomized run. A scoreboard checks every emitted
//   entry against an arithmetic reference model.
//   The bench honours IMM_ZEXT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic [2:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ImmExt;
    logic        ImmIllegal;

    logic        inReady64;
    logic        outValid64;
    logic [63:0] ImmExt64;
    logic        ImmIllegal64;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct packed {
        logic        ill;
        logic [63:0] imm;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] expImm;
        logic        expIll;
    } vec_t;

    exp_t  sbQ[$];
    exp_t  sbEntry;
    logic  heldPrev = 1'b0;
    logic [31:0] heldImm;
    vec_t  vecs[12];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .ImmSrc(ImmSrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .ImmExt(ImmExt), .ImmIllegal(ImmIllegal)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady64),
        .Instr(Instr), .ImmSrc(ImmSrc),
        .out_valid(outValid64), .out_ready(out_ready),
        .ImmExt(ImmExt64), .ImmIllegal(ImmIllegal64)
    );

    // Reference model. Each immediate is computed as a signed sum of weighted
    // instruction fields. The sign bit carries a negative weight, so the
    // 64-bit two's-complement result is the sign-extended value.
    function automatic exp_t refModel(input logic [31:0] ins, input logic [2:0] src);
        exp_t   r;
        longint v;
        r.ill = 1'b0;
        v     = 0;
        case (src)
            3'd0: v = longint'(ins[30:12]) * 4096 - longint'(ins[31]) * 64'sh8000_0000;
            3'd1: v = longint'(ins[30:20]) - longint'(ins[31]) * 2048;
            3'd2: v = 2 * longint'(ins[11:8]) + 32 * longint'(ins[30:25])
                      + 2048 * longint'(ins[7]) - 4096 * longint'(ins[31]);
            3'd3: v = longint'(ins[11:7]) + 32 * longint'(ins[30:25])
                      - 2048 * longint'(ins[31]);
            3'd4: v = 2 * longint'(ins[30:21]) + 2048 * longint'(ins[20])
                      + 4096 * longint'(ins[19:12]) - longint'(ins[31]) * 1048576;
`ifdef IMM_ZEXT_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: begin
                v     = 0;
                r.ill = 1'b1;
            end
        endcase
        r.imm = v;
        return r;
    endfunction

    // Record one comparison, and print a FAIL line when it does not match.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] ins,
                                 input logic [2:0] src, input logic ordy,
                                 input logic fl);
        in_valid  = iv;
        Instr     = ins;
        ImmSrc    = src;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, sampled on the falling edge while inputs are stable. An
    // emit pops the oldest expected entry, and an accept pushes a new one.
    // Flush and reset discard every entry still pending. A stalled output
    // must not change until it is emitted.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL sbUnexpectedEmit: got ImmExt=%h, expected no entry", ImmExt);
            end else begin
                sbEntry = sbQ.pop_front();
                checkOutput("sbImm32", {32'b0, ImmExt}, {32'b0, sbEntry.imm[31:0]});
                checkOutput("sbImm64", ImmExt64, sbEntry.imm);
                checkOutput("sbIll", {63'b0, ImmIllegal}, {63'b0, sbEntry.ill});
                checkOutput("sbValid64", {63'b0, outValid64}, 64'd1);
            end
        end
        if (heldPrev) begin
            checkOutput("holdStable", {31'b0, out_valid, ImmExt}, {31'b0, 1'b1, heldImm});
        end
        heldPrev = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst && !flush;
        heldImm  = ImmExt;
        if (rst === 1'b1 || flush === 1'b1) begin
            sbQ.delete();
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sbQ.push_back(refModel(Instr, ImmSrc));
        end
    end

    // Safety net, in case the run stops advancing.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        // Directed decode vectors: {instr, ImmSrc, expected ImmExt, expected ImmIllegal}
        vecs[0]  = '{32'hFFF00093, 3'b001, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0};  // beq x0,x0,-4
        vecs[2]  = '{32'h8000006F, 3'b100, 32'hFFF00000, 1'b0};
        vecs[3]  = '{32'h800002B7, 3'b000, 32'h80000000, 1'b0};
        vecs[4]  = '{32'h12345037, 3'b000, 32'h12345000, 1'b0};
        vecs[5]  = '{32'h7FF00093, 3'b001, 32'h000007FF, 1'b0};
        vecs[6]  = '{32'h00112623, 3'b011, 32'h0000000C, 1'b0};  // sw x1,12(x2)
        vecs[7]  = '{32'hFE112E23, 3'b011, 32'hFFFFFFFC, 1'b0};  // sw x1,-4(x2)
        vecs[8]  = '{32'hFFFFFFFF, 3'b110, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1};
        vecs[10] = '{32'h0040006F, 3'b100, 32'h00000004, 1'b0};  // jal x0,+4
`ifdef IMM_ZEXT_EN
        vecs[11] = '{32'h000FD073, 3'b101, 32'h0000001F, 1'b0};
`else
        vecs[11] = '{32'h000FD073, 3'b101, 32'h00000000, 1'b1};
`endif

        // Power-on reset
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b0, 1'b0);
        checkOutput("rstOutValid", {63'b0, out_valid}, 64'd0);
        checkOutput("rstInReady", {63'b0, in_ready}, 64'd0);
        checkOutput("rstImmExt", {32'b0, ImmExt}, 64'd0);
        checkOutput("rstImmIllegal", {63'b0, ImmIllegal}, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rstReleaseInReady", {63'b0, in_ready}, 64'd1);

        // Table-driven decode: accept one entry, check it one cycle later, drain
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].src, 1'b1, 1'b0);
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0dValid", i), {63'b0, out_valid}, 64'd1);
            checkOutput($sformatf("vec%0dImm", i), {32'b0, ImmExt}, {32'b0, vecs[i].expImm});
            checkOutput($sformatf("vec%0dIll", i), {63'b0, ImmIllegal}, {63'b0, vecs[i].expIll});
            checkOutput($sformatf("vec%0dImm64", i), ImmExt64,
                        {{32{vecs[i].expImm[31]}}, vecs[i].expImm});
            applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        end

        // Backpressure: three back-to-back entries, only two fit
        applyStimulus(1'b1, 32'h00500093, 3'b001, 1'b0, 1'b0);
        checkOutput("bpReadyAfter1", {63'b0, in_ready}, 64'd1);
        applyStimulus(1'b1, 32'hFFB00093, 3'b001, 1'b0, 1'b0);
        checkOutput("bpReadyAfter2", {63'b0, in_ready}, 64'd0);
        applyStimulus(1'b1, 32'h06300093, 3'b001, 1'b0, 1'b0);
        checkOutput("bpReadyAfter3", {63'b0, in_ready}, 64'd0);
        checkOutput("bpHeadImm", {32'b0, ImmExt}, 64'h5);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        checkOutput("bpSecondValid", {63'b0, out_valid}, 64'd1);
        checkOutput("bpSecondImm", {32'b0, ImmExt}, {32'b0, 32'hFFFFFFFB});
        checkOutput("bpReadyRecovered", {63'b0, in_ready}, 64'd1);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        checkOutput("bpDrained", {63'b0, out_valid}, 64'd0);

        // Flush with both slots full and a new entry offered
        applyStimulus(1'b1, 32'h00100093, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200093, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 3'b001, 1'b0, 1'b1);
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flushOutValid", {63'b0, out_valid}, 64'd0);
        checkOutput("flushInReady", {63'b0, in_ready}, 64'd1);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        checkOutput("flushNothingLater", {63'b0, out_valid}, 64'd0);

        // Flush in the same cycle as an accept into an empty buffer
        applyStimulus(1'b1, 32'h00400093, 3'b001, 1'b1, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushAcceptDropped", {63'b0, out_valid}, 64'd0);

        // Reset mid-stream with both slots occupied
        applyStimulus(1'b1, 32'hFFF00093, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h800002B7, 3'b000, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b0, 1'b0);
        checkOutput("midRstOutValid", {63'b0, out_valid}, 64'd0);
        checkOutput("midRstInReady", {63'b0, in_ready}, 64'd0);
        checkOutput("midRstImmExt", {32'b0, ImmExt}, 64'd0);
        checkOutput("midRstImmExt64", ImmExt64, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("midRstReleaseReady", {63'b0, in_ready}, 64'd1);

        // Randomized traffic checked by the scoreboard
        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end

        // Drain whatever is left and confirm nothing went missing
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 3'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("finalQueueEmpty", 64'(sbQ.size()), 64'd0);
        checkOutput("finalOutValid", {63'b0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
